mat_mul_seq_ctrl: RTL and testbench
===================================

// Module: mat_mul_seq_ctrl
// PURPOSE
//  Sequencer for an NxN integer matrix multiply using one shared MAC, one MAC step per cycle.
//  Captures operand matrices A,B through a valid/ready input handshake and walks i,j,k (k innermost).
//  Accumulates C[i][j] += A[i][k]*B[k][j] and presents C through a valid/ready output handshake.
//  Sits between the layer-level NN scheduler and downstream activation logic.
// PARAMETERS
//  DW     8   element width of A and B (unsigned)
//  N      2   matrix dimension (N>=2); one operation = N*N*N MAC steps
//  RES_W  8   width of each C element; result is taken mod 2^RES_W
// PORTS
//  clk        in   1          rising-edge clock
//  reset_n    in   1          asynchronous active-low reset
//  abort      in   1          synchronous abort; returns to IDLE from any state
//  in_valid   in   1          A/B operands valid
//  in_ready   out  1          block can accept operands (IDLE only)
//  a_flat     in   N*N*DW     matrix A, row-major, [0][0] in MSBs
//  b_flat     in   N*N*DW     matrix B, same packing
//  out_valid  out  1          res_flat holds a completed product
//  out_ready  in   1          consumer takes the result
//  res_flat   out  N*N*RES_W  matrix C, row-major, [0][0] in MSBs
//  busy       out  1          state != IDLE
//  op_count   out  16         completed output transfers, wraps 16'hFFFF -> 0
// BEHAVIOUR
//  Packing: element [r][c] is at bits ((N*N-1-(r*N+c))*W) +: W, where W = DW or RES_W.
//  Reset (reset_n=0, async): state=IDLE, indices=0, res_flat=0, op_count=0.
//    Outputs during reset: out_valid=0, busy=0, in_ready=1.
//  FSM: IDLE -> RUN on accept (in_valid & in_ready at a rising edge).
//    RUN -> DONE after the N^3-th MAC step.
//    DONE -> IDLE on out_ready & out_valid.
//    abort=1 at an edge -> IDLE from any state.
//  IDLE: in_ready=1. On accept: latch A and B, clear all C to 0, clear i,j,k to 0.
//  RUN: each edge performs one MAC step C[i][j] <= C[i][j] + A[i][k]*B[k][j].
//    Product is 2*DW bits. The sum is truncated to RES_W bits.
//    Then k++; if k wraps N->0 then j++; if j wraps N->0 then i++.
//    The step with i=j=k=N-1 is the last; the state moves to DONE on that edge.
//  Latency: accept on edge E0; MAC steps on edges E1..E(N^3); out_valid=1 after edge E(N^3).
//    For N=2 this is 8 cycles. Minimum period per operation: N^3+2 cycles.
//  DONE: out_valid=1. res_flat, in_ready=0 and busy=1 are held stable until the handshake.
//    Handshake edge: op_count++ and state returns to IDLE. No accept is possible on that same edge.
//  res_flat keeps its last value in IDLE. It changes only at accept (cleared), during RUN, or on abort.
//  Operands are latched at accept. a_flat/b_flat changes after accept have no effect.
//  abort: at the next edge go to IDLE, res_flat=0, indices=0, out_valid=0.
//    Aborted operations never raise out_valid and do not change op_count.
//    abort with in_valid in IDLE: abort wins, no accept.
//    abort with out_ready in DONE: the transfer completes (op_count++), then the abort clears res_flat.
//  in_valid is ignored outside IDLE. out_ready is ignored outside DONE.
// TESTING (N=2, DW=8, RES_W=8)
//  T1 Identity: A=32'h01000001, B=32'h01020304, out_ready=1.
//    -> res_flat=32'h01020304; out_valid rises 8 edges after accept and lasts 1 cycle; op_count=1.
//  T2 General: A=32'h01020304, B=32'h05060708.
//    -> res_flat=32'h13162B32; busy=1 from accept to handshake.
//  T3 Overflow: A=B=32'h0F0F0F0F.
//    -> each C = 450 mod 256, so res_flat=32'hC2C2C2C2.
//  T4 Backpressure: hold out_ready=0 for 5 cycles in DONE.
//    -> out_valid, res_flat and in_ready=0 stay stable; in_valid pulses are ignored.
//    -> op_count increments once, on the out_ready edge.
//  T5 Abort in RUN, 3 steps after accept.
//    -> IDLE next edge; res_flat=0; out_valid never rises; op_count unchanged.
//    -> a following operation (T2 operands) gives 32'h13162B32.
//  T6 Reset: drive reset_n low mid-RUN and mid-DONE.
//    -> all outputs go to reset values immediately, without waiting for clk.
//    -> after release, 3 back-to-back operations give op_count=3.

Source files
------------

// File: rtl/mat_mul_seq_ctrl.sv
// Sequencer for an NxN integer matrix multiply on one shared MAC, one MAC step per cycle (k innermost).
// Result valid N^3 cycles after accept; held stable in DONE until out_ready, operands accepted only in IDLE.
module mat_mul_seq_ctrl #(
    parameter int DW    = 8,
    parameter int N     = 2,
    parameter int RES_W = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 abort,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N*N*DW-1:0]    a_flat,
    input  logic [N*N*DW-1:0]    b_flat,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [N*N*RES_W-1:0] res_flat,
    output logic                 busy,
    output logic [15:0]          op_count
);

    localparam int IW = $clog2(N);
    localparam int PW = 2 * DW;
    localparam int SW = (RES_W > PW) ? RES_W : PW;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                 state_q, state_d;
    logic [N*N*DW-1:0]      a_q, a_d, b_q, b_d;
    logic [N*N*RES_W-1:0]   res_q, res_d;
    logic [IW-1:0]          i_q, i_d, j_q, j_d, k_q, k_d;
    logic [15:0]            op_count_q, op_count_d;

    logic [DW-1:0]          a_el [N][N];
    logic [DW-1:0]          b_el [N][N];
    logic [RES_W-1:0]       c_el [N][N];
    logic [PW-1:0]          prod;
    logic [RES_W-1:0]       mac_val;
    logic                   i_last, j_last, k_last;

    // Row-major unpacking, element [0][0] sits in the MSBs.
    for (genvar r = 0; r < N; r++) begin : g_row
        for (genvar c = 0; c < N; c++) begin : g_col
            assign a_el[r][c] = a_q[(N*N-1-(r*N+c))*DW +: DW];
            assign b_el[r][c] = b_q[(N*N-1-(r*N+c))*DW +: DW];
            assign c_el[r][c] = res_q[(N*N-1-(r*N+c))*RES_W +: RES_W];
        end
    end

    assign prod    = PW'(a_el[i_q][k_q]) * PW'(b_el[k_q][j_q]);
    assign mac_val = RES_W'(SW'(c_el[i_q][j_q]) + SW'(prod));
    assign i_last  = (i_q == IW'(N-1));
    assign j_last  = (j_q == IW'(N-1));
    assign k_last  = (k_q == IW'(N-1));

    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        res_d      = res_q;
        i_d        = i_q;
        j_d        = j_q;
        k_d        = k_q;
        op_count_d = op_count_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a_flat;
                    b_d     = b_flat;
                    res_d   = '0;
                    i_d     = '0;
                    j_d     = '0;
                    k_d     = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                for (int r = 0; r < N; r++) begin
                    for (int c = 0; c < N; c++) begin
                        if (IW'(r) == i_q && IW'(c) == j_q)
                            res_d[(N*N-1-(r*N+c))*RES_W +: RES_W] = mac_val;
                    end
                end
                k_d = k_last ? '0 : k_q + IW'(1);
                if (k_last) j_d = j_last ? '0 : j_q + IW'(1);
                if (k_last && j_last) i_d = i_last ? '0 : i_q + IW'(1);
                if (k_last && j_last && i_last) state_d = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    op_count_d = op_count_q + 16'd1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Abort overrides everything except a transfer completing on the same edge.
        if (abort) begin
            state_d = IDLE;
            res_d   = '0;
            i_d     = '0;
            j_d     = '0;
            k_d     = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            a_q        <= '0;
            b_q        <= '0;
            res_q      <= '0;
            i_q        <= '0;
            j_q        <= '0;
            k_q        <= '0;
            op_count_q <= '0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            res_q      <= res_d;
            i_q        <= i_d;
            j_q        <= j_d;
            k_q        <= k_d;
            op_count_q <= op_count_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign res_flat  = res_q;
    assign op_count  = op_count_q;

endmodule

// File: tb/tb_mat_mul_seq_ctrl.sv
// Bench for mat_mul_seq_ctrl (N=2, DW=8, RES_W=8): vector table, scoreboard queue, abort/reset/backpressure sequences.
module tb_mat_mul_seq_ctrl;

    logic        clk;
    logic        reset_n;
    logic        abort;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a_flat;
    logic [31:0] b_flat;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] res_flat;
    logic        busy;
    logic [15:0] op_count;

    mat_mul_seq_ctrl #(.DW(8), .N(2), .RES_W(8)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .abort     (abort),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_flat    (a_flat),
        .b_flat    (b_flat),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .res_flat  (res_flat),
        .busy      (busy),
        .op_count  (op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          bp;
    } vec_t;

    vec_t        vecs [8];
    logic [31:0] exp_q [$];
    int          n_checks = 0;
    int          n_fail   = 0;

    function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        logic [7:0]  acc;
        logic [15:0] p;
        r = '0;
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 2; j++) begin
                acc = '0;
                for (int k = 0; k < 2; k++) begin
                    p   = 16'(a[(3-(i*2+k))*8 +: 8]) * 16'(b[(3-(k*2+j))*8 +: 8]);
                    acc = acc + p[7:0];
                end
                r[(3-(i*2+j))*8 +: 8] = acc;
            end
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_accept(input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
        int guard = 0;
        while (!in_ready && guard < 40) begin
            step();
            guard++;
        end
        check("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
        a_flat   = a;
        b_flat   = b;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        exp_q.push_back(exp);
        a_flat = ~a;
        b_flat = ~b;
    endtask

    task automatic wait_done(output int lat, output int busy_bad);
        lat      = 0;
        busy_bad = 0;
        while (!out_valid && lat < 40) begin
            if (!busy) busy_bad++;
            step();
            lat++;
        end
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp, input int bp);
        int          lat, busy_bad;
        logic [31:0] held;
        logic [15:0] cnt0;
        out_ready = (bp == 0);
        do_accept(a, b, exp);
        cnt0 = op_count;
        wait_done(lat, busy_bad);
        check("latency", 32'(lat), 32'd8);
        check("busy_during_run", 32'(busy_bad), 32'd0);
        held = res_flat;
        for (int c = 0; c < bp; c++) begin
            in_valid = 1'b1;
            a_flat   = $urandom;
            step();
            check("bp_out_valid", {31'd0, out_valid}, 32'd1);
            check("bp_res_stable", res_flat, held);
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
            check("bp_op_count", {16'd0, op_count}, {16'd0, cnt0});
        end
        out_ready = 1'b1;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_empty: got no expectation, expected one");
        end else begin
            check("result", res_flat, exp_q.pop_front());
        end
        step();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("valid_one_cycle", {31'd0, out_valid}, 32'd0);
        check("idle_after_xfer", {31'd0, busy}, 32'd0);
        check("op_count_inc", {16'd0, op_count}, {16'd0, 16'(cnt0 + 16'd1)});
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
        check({tag, "_res_flat"}, res_flat, 32'd0);
        check({tag, "_op_count"}, {16'd0, op_count}, 32'd0);
    endtask

    initial begin
        int          lat, busy_bad, seen;
        logic [15:0] cnt0;

        vecs[0] = '{a: 32'h01000001, b: 32'h01020304, exp: 32'h01020304, bp: 0};
        vecs[1] = '{a: 32'h01020304, b: 32'h05060708, exp: 32'h13162B32, bp: 0};
        vecs[2] = '{a: 32'h0F0F0F0F, b: 32'h0F0F0F0F, exp: 32'hC2C2C2C2, bp: 0};
        vecs[3] = '{a: 32'hFFFFFFFF, b: 32'hFFFFFFFF, exp: 32'h02020202, bp: 0};
        vecs[4] = '{a: 32'h01020304, b: 32'h05060708, exp: 32'h13162B32, bp: 5};
        for (int v = 5; v < 8; v++) begin
            vecs[v].a   = $urandom;
            vecs[v].b   = $urandom;
            vecs[v].exp = model(vecs[v].a, vecs[v].b);
            vecs[v].bp  = v - 5;
        end

        reset_n   = 1'b0;
        abort     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a_flat    = '0;
        b_flat    = '0;
        #12;
        check_reset_outputs("reset");
        step();
        reset_n = 1'b1;
        step();

        for (int v = 0; v < 8; v++)
            run_op(vecs[v].a, vecs[v].b, vecs[v].exp, vecs[v].bp);
        check("op_count_after_table", {16'd0, op_count}, 32'd8);

        // Abort three MAC steps into RUN.
        cnt0 = op_count;
        do_accept(32'h01020304, 32'h05060708, 32'h0);
        void'(exp_q.pop_back());
        step();
        step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort_run_busy", {31'd0, busy}, 32'd0);
        check("abort_run_res", res_flat, 32'd0);
        seen = 0;
        for (int c = 0; c < 12; c++) begin
            if (out_valid) seen++;
            step();
        end
        check("abort_no_valid", 32'(seen), 32'd0);
        check("abort_op_count", {16'd0, op_count}, {16'd0, cnt0});
        run_op(32'h01020304, 32'h05060708, 32'h13162B32, 0);

        // Abort together with in_valid in IDLE: no accept.
        a_flat   = 32'h01020304;
        b_flat   = 32'h05060708;
        in_valid = 1'b1;
        abort    = 1'b1;
        step();
        in_valid = 1'b0;
        abort    = 1'b0;
        check("abort_idle_no_accept", {31'd0, busy}, 32'd0);

        // Abort together with out_ready in DONE: transfer counts, result cleared.
        cnt0      = op_count;
        out_ready = 1'b0;
        do_accept(32'h01000001, 32'h01020304, 32'h01020304);
        wait_done(lat, busy_bad);
        check("abort_done_result", res_flat, exp_q.pop_front());
        out_ready = 1'b1;
        abort     = 1'b1;
        step();
        out_ready = 1'b0;
        abort     = 1'b0;
        check("abort_done_count", {16'd0, op_count}, {16'd0, 16'(cnt0 + 16'd1)});
        check("abort_done_res", res_flat, 32'd0);
        check("abort_done_valid", {31'd0, out_valid}, 32'd0);

        // Asynchronous reset mid-RUN.
        do_accept(32'h01020304, 32'h05060708, 32'h0);
        exp_q.delete();
        step();
        step();
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_outputs("reset_run");
        step();
        reset_n = 1'b1;
        step();

        // Asynchronous reset mid-DONE.
        out_ready = 1'b0;
        do_accept(32'h0F0F0F0F, 32'h0F0F0F0F, 32'h0);
        exp_q.delete();
        wait_done(lat, busy_bad);
        check("pre_reset_done_valid", {31'd0, out_valid}, 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_outputs("reset_done");
        step();
        reset_n = 1'b1;
        step();

        for (int v = 0; v < 3; v++)
            run_op(vecs[v].a, vecs[v].b, vecs[v].exp, 0);
        check("op_count_after_reset", {16'd0, op_count}, 32'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
